pipeline_stall_ctrl: RTL and testbench

//  Consumes the ID-stage hazarddetected flag, the EXE-stage branch_taken flag and the memory

---
 rtl/pipeline_stall_ctrl.sv | 82 ++++++++
 tb/tb_pipeline_stall_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: turns hazard/branch/memory-ready/debug inputs into pipeline freeze, bubble and flush controls
// with saturating event counters and a hazard-stall watchdog.
module pipeline_stall_ctrl #(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hazarddetected,
  input  logic             i_branch_taken,
  input  logic             i_mem_ready,
  input  logic             i_halt_req,
  input  logic             i_resume,
  input  logic             i_perf_clr,
  output logic             o_freeze_pc,
  output logic             o_freeze_if_id,
  output logic             o_bubble_id_ex,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_freeze_all,
  output logic             o_halted,
  output logic             o_stall_timeout,
  output logic [CNT_W-1:0] o_hazard_cycles,
  output logic [CNT_W-1:0] o_mem_wait_cycles,
  output logic [CNT_W-1:0] o_flush_count
);
  typedef enum logic [1:0] {RUN, HAZ_STALL, MEM_WAIT, HALT} state_t;
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] MAX = SW'(MAX_STALL);
  state_t r_state, w_next;
  logic [SW-1:0] r_consec, w_consec_nxt;
  logic [CNT_W-1:0] r_hc, r_mw, r_fc;
  logic r_timeout, w_frz, w_halt, w_flush, w_haz;
  always_comb begin
    w_frz = rst_n & ~i_mem_ready;
    w_halt = rst_n & i_mem_ready & (r_state == HALT);
    w_flush = rst_n & i_mem_ready & (r_state != HALT) & i_branch_taken;
    w_haz = rst_n & i_mem_ready & (r_state != HALT) & ~i_branch_taken & i_hazarddetected;
    // A halted core stays halted through memory waits; only resume without halt_req releases it
    w_next = (r_state == HALT) ? ((i_resume & ~i_halt_req) ? RUN : HALT) :
             (i_halt_req & i_mem_ready) ? HALT :
             ~i_mem_ready ? MEM_WAIT :
             w_haz ? HAZ_STALL : RUN;
    w_consec_nxt = ~i_mem_ready ? r_consec :
                   w_haz ? ((r_consec == MAX) ? r_consec : r_consec + 1'b1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_consec <= '0;
      r_hc <= '0;
      r_mw <= '0;
      r_fc <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_consec <= w_consec_nxt;
      if (i_perf_clr) begin
        r_hc <= '0;
        r_mw <= '0;
        r_fc <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_haz && ~&r_hc) r_hc <= r_hc + 1'b1;
        if (w_frz && ~&r_mw) r_mw <= r_mw + 1'b1;
        if (w_flush && ~&r_fc) r_fc <= r_fc + 1'b1;
        if (w_consec_nxt == MAX) r_timeout <= 1'b1;
      end
    end
  end
  assign o_freeze_all = w_frz;
  assign o_freeze_pc = w_frz | w_halt | w_haz;
  assign o_freeze_if_id = w_frz | w_halt | w_haz;
  assign o_bubble_id_ex = w_halt | w_haz;
  assign o_flush_if_id = w_flush;
  assign o_flush_id_ex = w_flush;
  assign o_halted = (r_state == HALT);
  assign o_stall_timeout = r_timeout;
  assign o_hazard_cycles = r_hc;
  assign o_mem_wait_cycles = r_mw;
  assign o_flush_count = r_fc;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed + random stimulus, reference model feeds a scoreboard queue checked at negedge.
module tb_pipeline_stall_ctrl;
  localparam int MS = 8;
  logic clk = 0, rst_n = 0, hz = 0, br = 0, mr = 1, hr = 0, rs = 0, pc = 0;
  logic fpc, fif, bub, fli, fle, fa, hl, to;
  logic s_fpc, s_fif, s_bub, s_fli, s_fle, s_fa, s_hl, s_to;
  logic [31:0] hc, mw, fc;
  logic [3:0] shc, smw, sfc;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] hc, mw, fc;
    logic [3:0]  shc, smw, sfc;
  } exp_t;
  exp_t q[$];
  bit m_h, m_to;
  longint m_hc, m_mw, m_fc, m_shc, m_smw, m_sfc;
  int m_cons;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(32), .MAX_STALL(MS)) dut (
    .clk(clk), .rst_n(rst_n), .i_hazarddetected(hz), .i_branch_taken(br), .i_mem_ready(mr),
    .i_halt_req(hr), .i_resume(rs), .i_perf_clr(pc),
    .o_freeze_pc(fpc), .o_freeze_if_id(fif), .o_bubble_id_ex(bub), .o_flush_if_id(fli),
    .o_flush_id_ex(fle), .o_freeze_all(fa), .o_halted(hl), .o_stall_timeout(to),
    .o_hazard_cycles(hc), .o_mem_wait_cycles(mw), .o_flush_count(fc));

  pipeline_stall_ctrl #(.CNT_W(4), .MAX_STALL(MS)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_hazarddetected(hz), .i_branch_taken(br), .i_mem_ready(mr),
    .i_halt_req(hr), .i_resume(rs), .i_perf_clr(pc),
    .o_freeze_pc(s_fpc), .o_freeze_if_id(s_fif), .o_bubble_id_ex(s_bub), .o_flush_if_id(s_fli),
    .o_flush_id_ex(s_fle), .o_freeze_all(s_fa), .o_halted(s_hl), .o_stall_timeout(s_to),
    .o_hazard_cycles(shc), .o_mem_wait_cycles(smw), .o_flush_count(sfc));

  function automatic longint sat(longint v, longint cap);
    return (v + 1 > cap) ? cap : v + 1;
  endfunction

  task automatic step(input bit ihz, ibr, imr, ihr, irs, ipc, irn);
    exp_t e;
    bit efpc, ebub, efl, efa, r4;
    @(posedge clk);
    #1;
    hz = ihz; br = ibr; mr = imr; hr = ihr; rs = irs; pc = ipc; rst_n = irn;
    e = '{default: '0};
    if (!irn) begin
      m_h = 0; m_to = 0; m_cons = 0;
      m_hc = 0; m_mw = 0; m_fc = 0; m_shc = 0; m_smw = 0; m_sfc = 0;
    end else begin
      efa = !imr;
      efl = imr && !m_h && ibr;
      r4 = imr && !m_h && !ibr && ihz;
      ebub = (imr && m_h) || r4;
      efpc = efa || ebub;
      e.ctl = {efpc, efpc, ebub, efl, efl, efa, m_h, m_to};
      e.hc = 32'(m_hc); e.mw = 32'(m_mw); e.fc = 32'(m_fc);
      e.shc = 4'(m_shc); e.smw = 4'(m_smw); e.sfc = 4'(m_sfc);
      if (ipc) begin
        m_hc = 0; m_mw = 0; m_fc = 0; m_shc = 0; m_smw = 0; m_sfc = 0; m_to = 0;
      end else begin
        if (r4) begin m_hc = sat(m_hc, 64'hFFFF_FFFF); m_shc = sat(m_shc, 15); end
        if (efa) begin m_mw = sat(m_mw, 64'hFFFF_FFFF); m_smw = sat(m_smw, 15); end
        if (efl) begin m_fc = sat(m_fc, 64'hFFFF_FFFF); m_sfc = sat(m_sfc, 15); end
      end
      if (imr) m_cons = r4 ? m_cons + 1 : 0;
      if (!ipc && m_cons >= MS) m_to = 1;
      m_h = m_h ? !(irs && !ihr) : (ihr && imr);
    end
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, b, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ctl{fpc,fif,bub,fli,fle,fa,halted,timeout}", {24'd0, fpc, fif, bub, fli, fle, fa, hl, to}, {24'd0, e.ctl});
      chk("small_ctl", {24'd0, s_fpc, s_fif, s_bub, s_fli, s_fle, s_fa, s_hl, s_to}, {24'd0, e.ctl});
      chk("hazard_cycles", hc, e.hc);
      chk("mem_wait_cycles", mw, e.mw);
      chk("flush_count", fc, e.fc);
      chk("small_hazard_cycles", {28'd0, shc}, {28'd0, e.shc});
      chk("small_mem_wait_cycles", {28'd0, smw}, {28'd0, e.smw});
      chk("small_flush_count", {28'd0, sfc}, {28'd0, e.sfc});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    step(0,0,1,0,0,0,0); step(0,0,1,0,0,0,1);
    step(1,0,1,0,0,0,1); step(1,0,1,0,0,0,1); step(0,0,1,0,0,0,1); step(0,0,1,0,0,0,1);
    step(0,0,1,0,0,0,0);
    step(1,1,1,0,0,0,1); step(0,0,1,0,0,0,1); step(0,0,1,0,0,0,1);
    step(0,0,1,0,0,0,0);
    repeat (3) step(0,1,0,0,0,0,1);
    step(0,1,1,0,0,0,1); step(0,0,1,0,0,0,1); step(0,0,1,0,0,0,1);
    step(0,0,1,0,0,0,0);
    repeat (8) step(1,0,1,0,0,0,1);
    repeat (2) step(0,0,1,0,0,0,1);
    step(0,0,1,0,0,1,1); step(0,0,1,0,0,0,1);
    step(0,0,1,0,0,0,0);
    step(0,0,1,1,0,0,1); step(1,1,1,0,0,0,1); step(0,0,1,1,1,0,1); step(0,0,1,0,0,0,1);
    step(0,0,1,0,1,0,1); step(1,0,1,0,0,0,1); step(0,0,1,0,0,0,1);
    step(0,0,1,0,0,0,0);
    repeat (20) step(1,0,1,0,0,0,1);
    step(0,0,1,1,0,0,1); step(0,0,1,0,0,0,1); step(0,0,1,0,0,0,0); step(0,0,1,0,0,0,1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0,2) == 0, $urandom_range(0,4) == 0, $urandom_range(0,5) != 0,
           $urandom_range(0,15) == 0, $urandom_range(0,3) == 0, $urandom_range(0,60) == 0,
           $urandom_range(0,300) != 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
